bus8_cmd_master: RTL
====================

# bus8_cmd_master

Byte-stream command parser and Bus8 master. It sits between the UART byte receiver/transmitter and the Bus8 register blocks. It turns 'W' addr data and 'R' addr byte frames into single-cycle Bus8 write/read transactions, and returns read data, or a timeout code, as one response byte.

## Interface
Parameters:
- RD_TIMEOUT, 16: maximum cycles spent waiting for i_Bus_Rd_DV after a read strobe; legal range 1..255.
- TIMEOUT_BYTE, 8'hEE: response byte sent when a read times out.

Ports:
- i_Bus_Clk  in  1  block clock; all logic on rising edge.
- i_Bus_Rst_L  in  1  reset; asynchronous assert, active low.
- i_Cmd_DV  in  1  one-cycle strobe; i_Cmd_Byte valid.
- i_Cmd_Byte  in  8  received command-stream byte.
- i_Rsp_Busy  in  1  transmitter busy; response held while 1.
- o_Rsp_DV  out  1  one-cycle strobe; o_Rsp_Byte valid.
- o_Rsp_Byte  out  8  response byte (read data or TIMEOUT_BYTE).
- o_Bus_CS  out  1  bus chip select; one-cycle pulse per transaction.
- o_Bus_Wr_Rd_n  out  1  1 = write, 0 = read; valid while o_Bus_CS = 1.
- o_Bus_Addr8  out  8  bus address.
- o_Bus_Wr_Data  out  8  bus write data.
- i_Bus_Rd_Data  in  8  read data from slave.
- i_Bus_Rd_DV  in  1  read data valid strobe from slave.
- o_Err  out  1  one-cycle pulse: dropped byte or read timeout.

## Operation
- All outputs are registered.
- Reset value of every output is 0: o_Bus_CS, o_Bus_Wr_Rd_n, o_Bus_Addr8, o_Bus_Wr_Data, o_Rsp_DV, o_Rsp_Byte, o_Err. The FSM resets to IDLE and the timeout counter to 0.
- FSM states are IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, WAIT_RD, SEND_RSP.
- IDLE:
  - i_Cmd_DV with byte 8'h57 ('W') -> GET_ADDR, write mode.
  - i_Cmd_DV with byte 8'h52 ('R') -> GET_ADDR, read mode.
  - Any other byte -> dropped; o_Err pulses; stays IDLE.
- GET_ADDR: on i_Cmd_DV, latch the byte into o_Bus_Addr8. Write mode -> GET_DATA. Read mode -> BUS_RD.
- GET_DATA: on i_Cmd_DV, latch the byte into o_Bus_Wr_Data -> BUS_WR.
- BUS_WR: o_Bus_CS = 1 and o_Bus_Wr_Rd_n = 1 for exactly this one cycle -> IDLE. Writes produce no response byte.
- BUS_RD: o_Bus_CS = 1 and o_Bus_Wr_Rd_n = 0 for exactly this one cycle. Clear the counter -> WAIT_RD.
- WAIT_RD:
  - i_Bus_Rd_DV = 1 -> capture i_Bus_Rd_Data into o_Rsp_Byte -> SEND_RSP.
  - Otherwise the counter increments. When the counter equals RD_TIMEOUT-1 with no DV, load TIMEOUT_BYTE into o_Rsp_Byte, pulse o_Err, -> SEND_RSP.
  - DV on the final cycle wins over timeout.
- SEND_RSP: wait while i_Rsp_Busy = 1. When i_Rsp_Busy = 0, pulse o_Rsp_DV for one cycle -> IDLE.
- i_Cmd_DV arriving in BUS_WR, BUS_RD, WAIT_RD or SEND_RSP: byte dropped, o_Err pulses, state unaffected.
- i_Bus_Rd_DV outside WAIT_RD is ignored.
- o_Bus_Addr8 and o_Bus_Wr_Data hold their last values between transactions.
- Reset mid-frame or mid-transaction: the partial frame is discarded, o_Bus_CS and o_Rsp_DV drop immediately, the FSM returns to IDLE, and no response is sent.

## Timing
- Write: final data byte strobe in cycle N -> o_Bus_CS high in cycle N+1 only. The block accepts a new command byte from cycle N+2.
- Read, with a registered slave that returns DV one cycle after CS:
  - address strobe in cycle N -> o_Bus_CS high in cycle N+1;
  - i_Bus_Rd_DV in cycle N+2;
  - o_Rsp_DV in cycle N+3 if i_Rsp_Busy = 0.
- Read timeout: WAIT_RD occupies at most RD_TIMEOUT cycles. o_Err and SEND_RSP entry follow on the next edge.
- o_Rsp_DV and o_Err are never high for more than one consecutive cycle per event.
- o_Bus_CS is never high in two consecutive cycles.

## Test plan
- Write: bytes 57, 02, A5 -> one cycle of o_Bus_CS = 1, o_Bus_Wr_Rd_n = 1, o_Bus_Addr8 = 02, o_Bus_Wr_Data = A5, one cycle after the A5 strobe. No o_Rsp_DV.
- Read with a 4-register slave preloaded with reg01 = 3C: bytes 52, 01 -> CS read pulse, then o_Rsp_DV with o_Rsp_Byte = 3C three cycles after the 01 strobe.
- Read timeout with RD_TIMEOUT = 16 and no slave DV: bytes 52, 07 -> o_Err pulse, o_Rsp_Byte = EE, o_Rsp_DV exactly 16 cycles after WAIT_RD entry plus one.
- Backpressure: i_Rsp_Busy held 1 for 20 cycles during a read of 3C -> o_Rsp_DV occurs on the first cycle after Busy falls; byte = 3C.
- Bad and stray bytes:
  - byte 41 in IDLE -> o_Err pulse, no bus activity;
  - a byte during WAIT_RD -> o_Err pulse, read completes normally.
- Reset mid-frame: bytes 57, 02, then assert i_Bus_Rst_L = 0 -> all outputs 0. After release, bytes 52, 00 perform a clean read with no write ever issued.

Source files
------------

// File: rtl/bus8_cmd_master.sv
// Byte-stream command parser and Bus8 master: 'W' addr data / 'R' addr frames become
// single-cycle bus transactions; reads return one response byte (data or timeout code).
module bus8_cmd_master #(
  parameter int unsigned RD_TIMEOUT   = 16,
  parameter logic [7:0]  TIMEOUT_BYTE = 8'hEE
) (
  input  logic       i_Bus_Clk,
  input  logic       i_Bus_Rst_L,
  input  logic       i_Cmd_DV,
  input  logic [7:0] i_Cmd_Byte,
  input  logic       i_Rsp_Busy,
  output logic       o_Rsp_DV,
  output logic [7:0] o_Rsp_Byte,
  output logic       o_Bus_CS,
  output logic       o_Bus_Wr_Rd_n,
  output logic [7:0] o_Bus_Addr8,
  output logic [7:0] o_Bus_Wr_Data,
  input  logic [7:0] i_Bus_Rd_Data,
  input  logic       i_Bus_Rd_DV,
  output logic       o_Err
);

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] LastCnt  = 8'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StBusWr,
    StBusRd,
    StWaitRd,
    StSendRsp
  } state_e;

  state_e     state_q, state_d;
  logic       wr_mode_q, wr_mode_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cs_q, cs_d;
  logic       wr_rd_n_q, wr_rd_n_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rsp_dv_q, rsp_dv_d;
  logic [7:0] rsp_byte_q, rsp_byte_d;
  logic       err_q, err_d;

  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      state_q    <= StIdle;
      wr_mode_q  <= 1'b0;
      cnt_q      <= 8'd0;
      cs_q       <= 1'b0;
      wr_rd_n_q  <= 1'b0;
      addr_q     <= 8'd0;
      wdata_q    <= 8'd0;
      rsp_dv_q   <= 1'b0;
      rsp_byte_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_mode_q  <= wr_mode_d;
      cnt_q      <= cnt_d;
      cs_q       <= cs_d;
      wr_rd_n_q  <= wr_rd_n_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_dv_q   <= rsp_dv_d;
      rsp_byte_q <= rsp_byte_d;
      err_q      <= err_d;
    end
  end

  // Outputs are registered, so CS / Rsp_DV are launched on the edge that enters the state
  // in which they are visible.
  always_comb begin
    state_d    = state_q;
    wr_mode_d  = wr_mode_q;
    cnt_d      = cnt_q;
    cs_d       = 1'b0;
    wr_rd_n_d  = wr_rd_n_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_dv_d   = 1'b0;
    rsp_byte_d = rsp_byte_q;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_Cmd_DV) begin
          if (i_Cmd_Byte == CmdWrite) begin
            wr_mode_d = 1'b1;
            state_d   = StGetAddr;
          end else if (i_Cmd_Byte == CmdRead) begin
            wr_mode_d = 1'b0;
            state_d   = StGetAddr;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StGetAddr: begin
        if (i_Cmd_DV) begin
          addr_d = i_Cmd_Byte;
          if (wr_mode_q) begin
            state_d = StGetData;
          end else begin
            state_d   = StBusRd;
            cs_d      = 1'b1;
            wr_rd_n_d = 1'b0;
          end
        end
      end

      StGetData: begin
        if (i_Cmd_DV) begin
          wdata_d   = i_Cmd_Byte;
          state_d   = StBusWr;
          cs_d      = 1'b1;
          wr_rd_n_d = 1'b1;
        end
      end

      StBusWr: begin
        err_d   = i_Cmd_DV;
        state_d = StIdle;
      end

      StBusRd: begin
        err_d   = i_Cmd_DV;
        cnt_d   = 8'd0;
        state_d = StWaitRd;
      end

      StWaitRd: begin
        err_d = i_Cmd_DV;
        // Read data on the final cycle takes priority over the timeout.
        if (i_Bus_Rd_DV) begin
          rsp_byte_d = i_Bus_Rd_Data;
          rsp_dv_d   = !i_Rsp_Busy;
          state_d    = StSendRsp;
        end else if (cnt_q == LastCnt) begin
          rsp_byte_d = TIMEOUT_BYTE;
          rsp_dv_d   = !i_Rsp_Busy;
          err_d      = 1'b1;
          state_d    = StSendRsp;
        end else begin
          cnt_d = 8'(cnt_q + 8'd1);
        end
      end

      StSendRsp: begin
        err_d = i_Cmd_DV;
        if (rsp_dv_q) begin
          state_d = StIdle;
        end else if (!i_Rsp_Busy) begin
          rsp_dv_d = 1'b1;
          state_d  = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign o_Bus_CS      = cs_q;
  assign o_Bus_Wr_Rd_n = wr_rd_n_q;
  assign o_Bus_Addr8   = addr_q;
  assign o_Bus_Wr_Data = wdata_q;
  assign o_Rsp_DV      = rsp_dv_q;
  assign o_Rsp_Byte    = rsp_byte_q;
  assign o_Err         = err_q;

  cs_single_cycle: assert property (@(posedge i_Bus_Clk) disable iff (!i_Bus_Rst_L)
    o_Bus_CS |=> !o_Bus_CS);
  rsp_dv_single_cycle: assert property (@(posedge i_Bus_Clk) disable iff (!i_Bus_Rst_L)
    o_Rsp_DV |=> !o_Rsp_DV);

endmodule
